// File: rtl/diff_sat_if.sv
// Sample-stream bundle for the saturating comb stage.
// Ports: clear_i, valid_i, x_i (into stage); valid_o, y_o, clip_o, clip_cnt_o (out of stage).
interface diff_sat_if #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
);
    logic                 clear_i;
    logic                 valid_i;
    logic signed [DW-1:0] x_i;
    logic                 valid_o;
    logic signed [DW-1:0] y_o;
    logic                 clip_o;
    logic [CNT_W-1:0]     clip_cnt_o;

    modport slave (
        input  clear_i,
        input  valid_i,
        input  x_i,
        output valid_o,
        output y_o,
        output clip_o,
        output clip_cnt_o
    );

    modport master (
        output clear_i,
        output valid_i,
        output x_i,
        input  valid_o,
        input  y_o,
        input  clip_o,
        input  clip_cnt_o
    );
endinterface

// File: rtl/diff_sat.sv
// Saturating first-difference (comb) stage: y[n] = x[n] - x[n-DELAY], clipped to DW bits.
// Ports: clk, rst_n (sync, active low), bus (diff_sat_if.slave: clear/valid/x in, valid/y/clip/clip_cnt out).
// Optional macro DIFF_SAT_PRIME_EN: until DELAY samples are seen, subtract the first accepted
// sample instead of zero history, so the stream starts without a step transient.
module diff_sat #(
    parameter int DW    = 16,
    parameter int DELAY = 1,
    parameter int CNT_W = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    diff_sat_if.slave bus
);

    localparam int FW = $clog2(DELAY + 1);
    localparam logic [FW-1:0]        FILL_MAX = FW'(DELAY);
    localparam logic signed [DW-1:0] Y_MAX    = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] Y_MIN    = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    logic signed [DW-1:0] hist_q [DELAY];
    logic signed [DW-1:0] hist_d [DELAY];
    logic [FW-1:0]        fill_q, fill_d;
    logic                 valid_q;
    logic signed [DW-1:0] y_q, y_d;
    logic                 clip_q, clip_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic signed [DW-1:0] oldest;
    logic [DW:0]          diff;
    logic                 ovf;

    // hist_q[0] is the newest sample, hist_q[DELAY-1] is x[n-DELAY]
    always_comb begin
        hist_d[0] = bus.x_i;
        for (int i = 1; i < DELAY; i++) begin
            hist_d[i] = hist_q[i-1];
        end
    end

`ifdef DIFF_SAT_PRIME_EN
    logic signed [DW-1:0] first_q, first_d;

    // During fill the reference is the first sample; on the very
    // first sample that is x_i itself, so the first output is 0.
    always_comb begin
        first_d = first_q;
        if (fill_q == '0) begin
            first_d = bus.x_i;
        end
        if (fill_q == '0) begin
            oldest = bus.x_i;
        end else if (fill_q != FILL_MAX) begin
            oldest = first_q;
        end else begin
            oldest = hist_q[DELAY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q <= '0;
        end else if (bus.clear_i) begin
            first_q <= '0;
        end else if (bus.valid_i) begin
            first_q <= first_d;
        end
    end
`else
    always_comb begin
        oldest = hist_q[DELAY-1];
    end
`endif

    // One guard bit: overflow shows as the top two bits disagreeing,
    // and the top bit gives the direction of the clip.
    always_comb begin
        diff = {bus.x_i[DW-1], bus.x_i} - {oldest[DW-1], oldest};
        ovf  = diff[DW] ^ diff[DW-1];
        if (!ovf) begin
            y_d = diff[DW-1:0];
        end else if (diff[DW]) begin
            y_d = Y_MIN;
        end else begin
            y_d = Y_MAX;
        end
        clip_d = ovf;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clip_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        fill_d = fill_q;
        if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                hist_q[i] <= '0;
            end
            fill_q  <= '0;
            valid_q <= 1'b0;
            y_q     <= '0;
            clip_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.clear_i) begin
            // y_q and clip_q deliberately hold their last value
            for (int i = 0; i < DELAY; i++) begin
                hist_q[i] <= '0;
            end
            fill_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= bus.valid_i;
            if (bus.valid_i) begin
                for (int i = 0; i < DELAY; i++) begin
                    hist_q[i] <= hist_d[i];
                end
                fill_q <= fill_d;
                y_q    <= y_d;
                clip_q <= clip_d;
                cnt_q  <= cnt_d;
            end
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.y_o        = y_q;
    assign bus.clip_o     = clip_q;
    assign bus.clip_cnt_o = cnt_q;

endmodule

// File: doc/diff_sat.md
Name: diff_sat

Overview:
- Saturating first-difference (comb) stage for the audio path: y[n] = x[n] − x[n−DELAY], clipped to DW bits.
- Inverse of the saturating-add integrator stages; used to undo running sums and to build DC-blocking and comb effects.
- Sample-strobe driven, one result per valid input, registered output.
- Clip events are flagged per sample and counted for the control/monitor side.

Parameters:
- DW, 16: sample width, signed two's complement.
- DELAY, 1: comb delay in valid samples; legal range ≥1.
- CNT_W, 16: clip counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- clear_i  in  1  synchronous flush of history, fill state and clip counter
- valid_i  in  1  input sample strobe
- x_i  in  DW  input sample, signed
- valid_o  out  1  output strobe
- y_o  out  DW  difference, signed, saturated
- clip_o  out  1  asserted with valid_o when that y_o was clipped
- clip_cnt_o  out  CNT_W  number of clipped outputs since reset/clear, sticky at max

Behaviour:
- Reset: rst_n is sampled on a clk edge while low.
  - valid_o=0, y_o=0, clip_o=0, clip_cnt_o=0.
  - All DELAY history entries = 0; fill counter = 0.
- History: shift register of DELAY signed DW-bit entries.
  - Shifts only on valid_i; the newest x_i enters and the oldest (x[n−DELAY]) leaves.
  - No shift without valid_i, so gaps between strobes are transparent.
- Arithmetic:
  - diff = sext(x_i) − sext(oldest), computed in DW+1 bits.
  - If diff > 2^(DW−1)−1: y = 2^(DW−1)−1, clip=1.
  - If diff < −2^(DW−1): y = −2^(DW−1), clip=1.
  - Otherwise y = diff[DW−1:0], clip=0.
- Latency: exactly 1 clk from valid_i to valid_o. y_o and clip_o are updated only on that cycle and hold between strobes; clip_o is valid only when qualified by valid_o.
- Back-to-back valid_i on every clk is supported. There is no backpressure.
- Clip counter: increments by 1 on each output with clip=1. It saturates at 2^CNT_W−1 and does not wrap.
- clear_i: sets history=0, fill=0, clip_cnt_o=0 and valid_o=0 on the next cycle.
  - clear_i with valid_i in the same cycle: clear wins and the sample is dropped (no output).
  - y_o holds its last value.
- rst_n low takes priority over clear_i and valid_i.
- Reset mid-stream: any pending output is discarded, and valid_o is 0 on the cycle after reset.
- Fill counter: 0..DELAY. It increments on each accepted valid_i until it reaches DELAY and is then held. It affects behaviour only under the optional feature; without the feature it still runs for visibility in simulation.

Optional Feature:
- Macro DIFF_SAT_PRIME_EN.
- Defined (prime mode):
  - While fill < DELAY, the sample presented as x[n−DELAY] is the first sample accepted after reset/clear, not 0.
  - The first DELAY outputs are therefore x[n] − x[0]; the first output is 0, which avoids a startup step transient.
  - From fill == DELAY onward, the normal history is used.
  - Implementation: a first-sample register captured when fill==0 and valid_i.
- Undefined: history starts at zero, so the first DELAY outputs equal x[n] (saturation is still applied, though it cannot trigger).

Test Plan:
- DW=16, DELAY=1, no macro. Inputs 0, 100, 200, 150 → outputs 0, 100, 100, −50, each 1 clk after its strobe, clip_o=0.
- DELAY=1. Inputs 32767 then −32768 → second output −32768, clip_o=1, clip_cnt_o=1. Then −32768 then 32767 → 32767, clip_o=1, clip_cnt_o=2.
- DELAY=3. Inputs 10, 20, 30, 40, 50 with 0–4 idle clocks between strobes → outputs 10, 20, 30, 30, 30; valid_o count equals valid_i count.
- CNT_W=2. Five consecutive clipping pairs → clip_cnt_o goes 1, 2, 3, 3, 3 and sticks; clear_i → 0 next cycle.
- clear_i and valid_i in the same cycle mid-stream (x=500 dropped), then input 700 → no output for 500; 700 − 0 = 700 output, because the history was zeroed.
- DIFF_SAT_PRIME_EN, DELAY=2. Inputs 1000, 1010, 1030, 1060 → outputs 0, 10, 30, 50. Then rst_n low for 1 clk mid-stream → valid_o=0 and priming restarts on the next sample.
